cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  N-channel result-bus (CDB) arbiter for the OoO pipe: functional units (ch0=ALU, ch1=LS, ...)
//  raise req when a result is ready; one channel per cycle drives the writeback/CDB.
//  Generalises the 2-input ALU/LS arbiter to N_CH channels with fixed or round-robin
//  priority, downstream backpressure and anti-starvation aging.
//  Sits between execution units' result regs and the CDB/ROB writeback port.
// PARAMETERS
//  N_CH      2   number of requesting channels (>=2)
//  MODE      1   0 = fixed priority (ch0 highest), 1 = round-robin
//  MAX_WAIT  4   consecutive lost cycles before a channel is force-granted; 0 disables aging
//  CNT_W     16  width of each perf stall counter (CDB_PERF_CNT_EN only)
// PORTS
//  clk             in   1           clock, all state on posedge
//  rst             in   1           reset, asynchronous, active-high
//  req             in   N_CH        per-channel result-ready request
//  cdb_busy        in   1           downstream cannot accept a result this cycle
//  gnt             out  N_CH        one-hot grant (all-zero when nothing granted)
//  gnt_vld         out  1           |gnt
//  sel_result      out  SEL_W       binary index of granted ch; SEL_W = max(1,$clog2(N_CH)); 0 if none
//  stall           out  N_CH        req & ~gnt: channel must hold its result
//  perf_stall_cnt  out  N_CH*CNT_W  per-channel stall counters, ch i at [i*CNT_W +: CNT_W] (macro only)
// BEHAVIOUR
//  - Grant is combinational from req, cdb_busy and registered state: zero-cycle latency.
//  - Reset (rst=1, async): rr_ptr=0, wait_cnt[*]=0, perf cnts=0; while rst=1: gnt=0,
//    gnt_vld=0, sel_result=0, stall=req. Reset mid-request drops any pending priority history.
//  - cdb_busy=1: gnt=0, stall=req; rr_ptr and wait_cnt hold.
//  - Pick order (cdb_busy=0, req!=0):
//    1. Aged: any ch with req[i] && wait_cnt[i]==MAX_WAIT (MAX_WAIT>0) -> lowest such index wins.
//    2. Else MODE=0: lowest-index req. MODE=1: first req scanning rr_ptr, rr_ptr+1, ... wrapping mod N_CH.
//  - rr_ptr update (MODE=1, any grant k): rr_ptr <= (k+1) mod N_CH (wraps N_CH-1 -> 0). No grant: hold.
//    MODE=0: rr_ptr unused, held at 0.
//  - wait_cnt[i] next: 0 if !req[i] or gnt[i]; hold if cdb_busy; else min(wait_cnt[i]+1, MAX_WAIT).
//  - req=0: gnt=0, sel_result=0, stall=0, no state change except wait_cnt clears.
//  - Exactly one gnt bit when gnt_vld; gnt only set on a requesting channel.
// CONFIGURATION
//  CDB_PERF_CNT_EN defined: perf_stall_cnt present; cnt[i] += 1 each cycle stall[i]=1,
//    saturating at all-ones; cleared only by rst.
//  CDB_PERF_CNT_EN undefined: port and counters absent; arbitration identical.
// STRUCTURE
//  Package cdb_arb_pkg: localparams ARB_MODE_FIXED=0, ARB_MODE_RR=1, CH_ALU=0, CH_LS=1,
//    function onehot2idx (one-hot -> binary index).
//  Sub-module rr_prio_pick: combinational rotating-priority picker (req, base ptr -> one-hot);
//    instanced twice: aged-set pick (base 0) and normal pick (base rr_ptr, or 0 for MODE=0).
//  Top holds rr_ptr, wait_cnt array, perf counters, output muxing.
// TESTING
//  1. N_CH=2,MODE=1: req=2'b11 held 4 cyc after rst -> gnt 01,10,01,10; sel_result 0,1,0,1; stall mirrors.
//  2. N_CH=4,MODE=1: rr_ptr=3 (after grant to ch2), req=4'b1001 -> gnt=4'b1000, next cycle gnt=4'b0001 (wrap).
//  3. N_CH=4,MODE=0,MAX_WAIT=3: req=4'b0011 constant -> ch0 granted cyc0-2, ch1 forced cyc3, wait_cnt[1] clears.
//  4. req=2'b11, cdb_busy=1 for 3 cyc -> gnt=0, stall=2'b11, rr_ptr/wait_cnt frozen; grant resumes same order.
//  5. rst asserted mid-stream with req=2'b10 -> outputs gnt=0, stall=2'b10 immediately (async); after release rr_ptr=0.
//  6. CDB_PERF_CNT_EN, N_CH=2,CNT_W=4: ch1 stalled 20 cyc -> perf cnt ch1 saturates at 4'hF; ch0 count = its stall cycles.

Source files
------------

// File: rtl/cdb_arb_pkg.sv
// rtl/cdb_arb_pkg.sv - shared constants and index helper for the CDB result-bus arbiter
package cdb_arb_pkg;

  localparam int ARB_MODE_FIXED = 0;
  localparam int ARB_MODE_RR    = 1;
  localparam int CH_ALU         = 0;
  localparam int CH_LS          = 1;
  localparam int OH_MAX         = 32;

  function automatic logic [4:0] onehot2idx(input logic [OH_MAX-1:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < OH_MAX; i++) begin
      if (oh[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// rtl/rr_prio_pick.sv - combinational rotating-priority picker (first request at or after base)
module rr_prio_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] base,
  output logic [N-1:0]  gnt
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] gnt_dbl;
  logic [N-1:0]   rot_req;
  logic [N-1:0]   rot_gnt;

  // Rotate so base lands on bit 0, take the lowest set bit, rotate back.
  always_comb begin
    req_dbl = {req, req} >> base;
    rot_req = req_dbl[N-1:0];
    rot_gnt = rot_req & (~rot_req + N'(1));
    gnt_dbl = {rot_gnt, rot_gnt} << base;
    gnt     = gnt_dbl[2*N-1:N];
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - N-channel CDB writeback arbiter, fixed/round-robin with aging.
// Optional per-channel stall counters enabled by defining CDB_PERF_CNT_EN.
module cdb_arbiter
  import cdb_arb_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int MODE     = 1,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16,
  localparam int SEL_W   = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   req,
  input  logic              cdb_busy,
  output logic [N_CH-1:0]   gnt,
  output logic              gnt_vld,
  output logic [SEL_W-1:0]  sel_result,
  output logic [N_CH-1:0]   stall
`ifdef CDB_PERF_CNT_EN
  ,
  output logic [N_CH*CNT_W-1:0] perf_stall_cnt
`endif
);

  localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d, base_ptr;
  logic [WAIT_W-1:0] wait_cnt_q [N_CH];
  logic [WAIT_W-1:0] wait_cnt_d [N_CH];
  logic [N_CH-1:0]   aged, aged_gnt, norm_gnt;

  if (N_CH < 2 || N_CH > OH_MAX || CNT_W < 1) begin : g_bad_cfg
    $error("cdb_arbiter: unsupported N_CH/CNT_W");
  end

  always_comb begin
    aged = '0;
    for (int i = 0; i < N_CH; i++) begin
      aged[i] = (MAX_WAIT > 0) && req[i] && (wait_cnt_q[i] == WAIT_LIM);
    end
  end

  assign base_ptr = (MODE == ARB_MODE_FIXED) ? '0 : rr_ptr_q;

  rr_prio_pick #(.N(N_CH), .PW(SEL_W)) u_aged_pick (
    .req (aged),
    .base({SEL_W{1'b0}}),
    .gnt (aged_gnt)
  );

  rr_prio_pick #(.N(N_CH), .PW(SEL_W)) u_norm_pick (
    .req (req),
    .base(base_ptr),
    .gnt (norm_gnt)
  );

  always_comb begin
    gnt = '0;
    if (!rst && !cdb_busy) gnt = (|aged) ? aged_gnt : norm_gnt;
    gnt_vld    = |gnt;
    stall      = req & ~gnt;
    sel_result = SEL_W'(onehot2idx(OH_MAX'(gnt)));

    rr_ptr_d = rr_ptr_q;
    if (MODE == ARB_MODE_RR && gnt_vld) begin
      rr_ptr_d = (sel_result == SEL_W'(N_CH - 1)) ? '0 : sel_result + SEL_W'(1);
    end

    // Losers age while the bus is free; a busy bus freezes everyone's age.
    for (int i = 0; i < N_CH; i++) begin
      wait_cnt_d[i] = wait_cnt_q[i];
      if (!req[i] || gnt[i]) begin
        wait_cnt_d[i] = '0;
      end else if (!cdb_busy && wait_cnt_q[i] != WAIT_LIM) begin
        wait_cnt_d[i] = wait_cnt_q[i] + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      for (int i = 0; i < N_CH; i++) wait_cnt_q[i] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < N_CH; i++) wait_cnt_q[i] <= wait_cnt_d[i];
    end
  end

`ifdef CDB_PERF_CNT_EN
  logic [CNT_W-1:0] perf_q [N_CH];
  logic [CNT_W-1:0] perf_d [N_CH];

  always_comb begin
    perf_stall_cnt = '0;
    for (int i = 0; i < N_CH; i++) begin
      perf_d[i] = perf_q[i];
      if (stall[i] && perf_q[i] != '1) perf_d[i] = perf_q[i] + CNT_W'(1);
      perf_stall_cnt[i*CNT_W +: CNT_W] = perf_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) perf_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) perf_q[i] <= perf_d[i];
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed vector bench for cdb_arbiter (2ch RR, 4ch RR, 4ch fixed+aging)
module tb_cdb_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0] req_a, gnt_a, stall_a;
  logic       busy_a, vld_a, sel_a;
  logic [3:0] req_b, gnt_b, stall_b;
  logic       busy_b, vld_b;
  logic [1:0] sel_b;
  logic [3:0] req_c, gnt_c, stall_c;
  logic       busy_c, vld_c;
  logic [1:0] sel_c;
`ifdef CDB_PERF_CNT_EN
  logic [7:0]  perf_a;
  logic [63:0] perf_b, perf_c;
`endif

  cdb_arbiter #(.N_CH(2), .MODE(1), .MAX_WAIT(4), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .cdb_busy(busy_a), .gnt(gnt_a),
    .gnt_vld(vld_a), .sel_result(sel_a), .stall(stall_a)
`ifdef CDB_PERF_CNT_EN
    , .perf_stall_cnt(perf_a)
`endif
  );

  cdb_arbiter #(.N_CH(4), .MODE(1), .MAX_WAIT(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .cdb_busy(busy_b), .gnt(gnt_b),
    .gnt_vld(vld_b), .sel_result(sel_b), .stall(stall_b)
`ifdef CDB_PERF_CNT_EN
    , .perf_stall_cnt(perf_b)
`endif
  );

  cdb_arbiter #(.N_CH(4), .MODE(0), .MAX_WAIT(3), .CNT_W(16)) dut_c (
    .clk(clk), .rst(rst), .req(req_c), .cdb_busy(busy_c), .gnt(gnt_c),
    .gnt_vld(vld_c), .sel_result(sel_c), .stall(stall_c)
`ifdef CDB_PERF_CNT_EN
    , .perf_stall_cnt(perf_c)
`endif
  );

  typedef struct {
    int         dut;
    logic [3:0] req;
    logic       busy;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [3:0] stall;
  } vec_t;

  vec_t tv[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic add(input int d, input logic [3:0] r, input logic b,
                     input logic [3:0] g, input logic [1:0] s, input logic [3:0] st);
    vec_t v;
    v.dut = d; v.req = r; v.busy = b; v.gnt = g; v.sel = s; v.stall = st;
    tv.push_back(v);
  endtask

  task automatic idle_inputs();
    req_a = '0; req_b = '0; req_c = '0;
    busy_a = 1'b0; busy_b = 1'b0; busy_c = 1'b0;
  endtask

  task automatic step_a(input string nm, input logic [1:0] r, input logic b,
                        input logic [1:0] g, input logic s, input logic [1:0] st);
    @(negedge clk);
    req_a = r; busy_a = b;
    #1;
    chk({nm, ".gnt"}, 32'(gnt_a), 32'(g));
    chk({nm, ".sel"}, 32'(sel_a), 32'(s));
    chk({nm, ".stall"}, 32'(stall_a), 32'(st));
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    req_a = 2'b11;
    #2;
    chk("rst.gnt", 32'(gnt_a), 32'h0);
    chk("rst.vld", 32'(vld_a), 32'h0);
    chk("rst.sel", 32'(sel_a), 32'h0);
    chk("rst.stall", 32'(stall_a), 32'h3);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req_a = '0;

    // A: 2ch round-robin alternation, busy freeze, idle, single requests
    add(0, 4'b11, 0, 4'b01, 0, 4'b10);
    add(0, 4'b11, 0, 4'b10, 1, 4'b01);
    add(0, 4'b11, 0, 4'b01, 0, 4'b10);
    add(0, 4'b11, 0, 4'b10, 1, 4'b01);
    add(0, 4'b11, 1, 4'b00, 0, 4'b11);
    add(0, 4'b11, 1, 4'b00, 0, 4'b11);
    add(0, 4'b11, 1, 4'b00, 0, 4'b11);
    add(0, 4'b11, 0, 4'b01, 0, 4'b10);
    add(0, 4'b00, 0, 4'b00, 0, 4'b00);
    add(0, 4'b01, 0, 4'b01, 0, 4'b00);
    add(0, 4'b10, 0, 4'b10, 1, 4'b00);
    add(0, 4'b10, 0, 4'b10, 1, 4'b00);
    // B: 4ch round-robin, pointer wrap from 3 to 0
    add(1, 4'b0100, 0, 4'b0100, 2, 4'b0000);
    add(1, 4'b1001, 0, 4'b1000, 3, 4'b0001);
    add(1, 4'b1001, 0, 4'b0001, 0, 4'b1000);
    add(1, 4'b1111, 0, 4'b0010, 1, 4'b1101);
    add(1, 4'b1011, 0, 4'b1000, 3, 4'b0011);
    add(1, 4'b0110, 0, 4'b0010, 1, 4'b0100);
    add(1, 4'b1111, 1, 4'b0000, 0, 4'b1111);
    add(1, 4'b1111, 0, 4'b0100, 2, 4'b1011);
    // C: fixed priority with aging at MAX_WAIT=3
    for (int k = 0; k < 2; k++) begin
      add(2, 4'b0011, 0, 4'b0001, 0, 4'b0010);
      add(2, 4'b0011, 0, 4'b0001, 0, 4'b0010);
      add(2, 4'b0011, 0, 4'b0001, 0, 4'b0010);
      add(2, 4'b0011, 0, 4'b0010, 1, 4'b0001);
    end
    add(2, 4'b0000, 0, 4'b0000, 0, 4'b0000);
    add(2, 4'b0111, 0, 4'b0001, 0, 4'b0110);
    add(2, 4'b0111, 0, 4'b0001, 0, 4'b0110);
    add(2, 4'b0111, 1, 4'b0000, 0, 4'b0111);
    add(2, 4'b0111, 0, 4'b0001, 0, 4'b0110);
    add(2, 4'b0111, 0, 4'b0010, 1, 4'b0101);
    add(2, 4'b0111, 0, 4'b0100, 2, 4'b0011);
    add(2, 4'b0111, 0, 4'b0001, 0, 4'b0110);
    add(2, 4'b1100, 0, 4'b0100, 2, 4'b1000);
    add(2, 4'b1000, 0, 4'b1000, 3, 4'b0000);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      idle_inputs();
      case (tv[i].dut)
        0: begin req_a = tv[i].req[1:0]; busy_a = tv[i].busy; end
        1: begin req_b = tv[i].req;      busy_b = tv[i].busy; end
        default: begin req_c = tv[i].req; busy_c = tv[i].busy; end
      endcase
      #1;
      case (tv[i].dut)
        0: begin
          chk($sformatf("v%0d.gnt", i), 32'(gnt_a), 32'(tv[i].gnt[1:0]));
          chk($sformatf("v%0d.vld", i), 32'(vld_a), 32'(|tv[i].gnt));
          chk($sformatf("v%0d.sel", i), 32'(sel_a), 32'(tv[i].sel[0]));
          chk($sformatf("v%0d.stall", i), 32'(stall_a), 32'(tv[i].stall[1:0]));
        end
        1: begin
          chk($sformatf("v%0d.gnt", i), 32'(gnt_b), 32'(tv[i].gnt));
          chk($sformatf("v%0d.vld", i), 32'(vld_b), 32'(|tv[i].gnt));
          chk($sformatf("v%0d.sel", i), 32'(sel_b), 32'(tv[i].sel));
          chk($sformatf("v%0d.stall", i), 32'(stall_b), 32'(tv[i].stall));
        end
        default: begin
          chk($sformatf("v%0d.gnt", i), 32'(gnt_c), 32'(tv[i].gnt));
          chk($sformatf("v%0d.vld", i), 32'(vld_c), 32'(|tv[i].gnt));
          chk($sformatf("v%0d.sel", i), 32'(sel_c), 32'(tv[i].sel));
          chk($sformatf("v%0d.stall", i), 32'(stall_c), 32'(tv[i].stall));
        end
      endcase
    end
    idle_inputs();

    // Async reset mid-stream: pointer is 1 when rst hits, must restart from ch0
    step_a("pre_rst", 2'b01, 0, 2'b01, 0, 2'b00);
    @(negedge clk);
    req_a = 2'b10;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst.gnt", 32'(gnt_a), 32'h0);
    chk("mid_rst.vld", 32'(vld_a), 32'h0);
    chk("mid_rst.stall", 32'(stall_a), 32'h2);
    @(negedge clk);
    rst = 1'b0;
    step_a("post_rst", 2'b11, 0, 2'b01, 0, 2'b10);
    step_a("post_rst2", 2'b11, 0, 2'b10, 1, 2'b01);

`ifdef CDB_PERF_CNT_EN
    @(negedge clk);
    rst = 1'b1;
    req_a = '0;
    #1;
    chk("perf.rst", 32'(perf_a), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) step_a("perf.s0", 2'b01, 1, 2'b00, 0, 2'b01);
    for (int k = 0; k < 20; k++) step_a("perf.s1", 2'b10, 1, 2'b00, 0, 2'b10);
    step_a("perf.idle", 2'b00, 0, 2'b00, 0, 2'b00);
    chk("perf.ch0", 32'(perf_a[3:0]), 32'h3);
    chk("perf.ch1", 32'(perf_a[7:4]), 32'hF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
